// File: rtl/hmulti_sink_pkg.sv
// hmulti_sink_pkg
// Shared constants for the multi-channel terminal sink: on/off levels,
// default field widths, default req debounce depth, channel FSM state
// encodings and a small popcount helper used by the total counter.
package hmulti_sink_pkg;

    localparam logic NS_ON  = 1'b1;
    localparam logic NS_OFF = 1'b0;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 2;
    localparam int NS_REQ_CKS      = 3;

    localparam logic [1:0] NS_SNK_IDLE  = 2'd0;
    localparam logic [1:0] NS_SNK_ACKED = 2'd1;
    localparam logic [1:0] NS_SNK_ERR   = 2'd2;

    // Number of set bits in a 16-bit vector (up to 16 channels).
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/hmsink_debouncer.sv
// hmsink_debouncer
// Debounces one 4-phase request line. ckd_req rises on the edge where the
// run of consecutive high samples reaches REQ_CKS and falls on the first
// edge that samples req low.
// Ports:
//   clk     - clock
//   reset   - asynchronous, active-high reset
//   req     - raw request
//   ckd_req - debounced request
//   rdy     - idle: no run in progress and ckd_req low
module hmsink_debouncer
    import hmulti_sink_pkg::*;
#(
    parameter int REQ_CKS = NS_REQ_CKS
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic ckd_req,
    output logic rdy
);

    localparam int CW = $clog2(REQ_CKS + 1);
    localparam logic [CW-1:0] CKS_L = CW'(REQ_CKS);

    logic [CW-1:0] cnt_r;
    logic          ckd_r;

    // Run-length counter of high samples; holds at REQ_CKS once qualified.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CW'(0);
            ckd_r <= NS_OFF;
        end else if (!req) begin
            cnt_r <= CW'(0);
            ckd_r <= NS_OFF;
        end else if (!ckd_r) begin
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CKS_L - CW'(1)) begin
                ckd_r <= NS_ON;
            end else begin
                ckd_r <= NS_OFF;
            end
        end else begin
            cnt_r <= cnt_r;
            ckd_r <= ckd_r;
        end
    end

    assign ckd_req = ckd_r;
    assign rdy     = (cnt_r == CW'(0)) && !ckd_r;

endmodule

// File: rtl/hmulti_sink.sv
// hmulti_sink
// Multi-channel terminal sink. Each channel debounces its req, checks dst
// against MY_LOCAL_ADDR and acks matching messages; a mismatch parks the
// channel in ERR until reset. Keeps per-channel counters, a global
// saturating total, an XOR of accepted data, a sticky done flag and a
// sticky first-error record (lowest channel wins on ties).
// Ports:
//   gch_clk, gch_reset         - clock, async active-high reset
//   gch_ready                  - initialised and all debouncers idle
//   rcv_req/rcv_ack_out        - per-channel 4-phase handshake
//   rcv_src/dst/dat/red        - per-channel message fields (red unused)
//   msg_cnt                    - per-channel saturating accept counts
//   dat_xor                    - XOR of all accepted data
//   done                       - total accepted reached EXPECTED
//   err0_*                     - first error: flag, channel, src, dst, dat
module hmulti_sink
    import hmulti_sink_pkg::*;
#(
    parameter int MY_LOCAL_ADDR = 0,
    parameter int NUM_CHNLS     = 2,
    parameter int ASZ           = NS_ADDRESS_SIZE,
    parameter int DSZ           = NS_DATA_SIZE,
    parameter int RSZ           = NS_REDUN_SIZE,
    parameter int CNT_SZ        = 8,
    parameter int EXPECTED      = 0,
    parameter int RCV_REQ_CKS   = NS_REQ_CKS,
    parameter int CHW           = 4
) (
    input  logic                      gch_clk,
    input  logic                      gch_reset,
    output logic                      gch_ready,
    input  logic [NUM_CHNLS-1:0]      rcv_req,
    output logic [NUM_CHNLS-1:0]      rcv_ack_out,
    input  logic [NUM_CHNLS*ASZ-1:0]  rcv_src,
    input  logic [NUM_CHNLS*ASZ-1:0]  rcv_dst,
    input  logic [NUM_CHNLS*DSZ-1:0]  rcv_dat,
    input  logic [NUM_CHNLS*RSZ-1:0]  rcv_red,
    output logic [NUM_CHNLS*CNT_SZ-1:0] msg_cnt,
    output logic [DSZ-1:0]            dat_xor,
    output logic                      done,
    output logic                      err0_error,
    output logic [CHW-1:0]            err0_chn,
    output logic [ASZ-1:0]            err0_src,
    output logic [ASZ-1:0]            err0_dst,
    output logic [DSZ-1:0]            err0_dat
);

    localparam int TOT_SZ = CNT_SZ + $clog2(NUM_CHNLS);
    localparam int SUM_SZ = TOT_SZ + 5;
    localparam logic [TOT_SZ-1:0] TOT_MAX = {TOT_SZ{1'b1}};
    localparam logic [ASZ-1:0]    MY_ADDR_L = ASZ'(MY_LOCAL_ADDR);

    logic [NUM_CHNLS-1:0] ckd_s;
    logic [NUM_CHNLS-1:0] rdy_s;
    logic [NUM_CHNLS-1:0] accept_s;
    logic [NUM_CHNLS-1:0] err_s;

    logic                 init_r;
    logic [TOT_SZ-1:0]    total_r;
    logic [DSZ-1:0]       dat_xor_r;
    logic                 done_r;
    logic                 err_r;
    logic [CHW-1:0]       err_chn_r;
    logic [ASZ-1:0]       err_src_r;
    logic [ASZ-1:0]       err_dst_r;
    logic [DSZ-1:0]       err_dat_r;

    logic [DSZ-1:0]       xor_next_s;
    logic [4:0]           pop_s;
    logic [SUM_SZ-1:0]    sum_s;
    logic [TOT_SZ-1:0]    total_next_s;
    logic                 done_next_s;
    logic                 err_any_s;
    logic [CHW-1:0]       err_sel_chn_s;
    logic [ASZ-1:0]       err_sel_src_s;
    logic [ASZ-1:0]       err_sel_dst_s;
    logic [DSZ-1:0]       err_sel_dat_s;
    logic                 unused_red_s;

    assign unused_red_s = ^rcv_red;

    for (genvar g = 0; g < NUM_CHNLS; g++) begin : g_chn
        logic [1:0]        state_r;
        logic              ack_r;
        logic [CNT_SZ-1:0] cnt_r;
        logic              dst_ok_s;

        hmsink_debouncer #(
            .REQ_CKS (RCV_REQ_CKS)
        ) u_deb (
            .clk     (gch_clk),
            .reset   (gch_reset),
            .req     (rcv_req[g]),
            .ckd_req (ckd_s[g]),
            .rdy     (rdy_s[g])
        );

        assign dst_ok_s    = (rcv_dst[g*ASZ +: ASZ] == MY_ADDR_L);
        assign accept_s[g] = (state_r == NS_SNK_IDLE) && ckd_s[g] && dst_ok_s;
        assign err_s[g]    = (state_r == NS_SNK_IDLE) && ckd_s[g] && !dst_ok_s;

        // Channel handshake FSM; ERR is absorbing until reset.
        always_ff @(posedge gch_clk or posedge gch_reset) begin
            if (gch_reset) begin
                state_r <= NS_SNK_IDLE;
                ack_r   <= NS_OFF;
            end else begin
                case (state_r)
                    NS_SNK_IDLE: begin
                        if (accept_s[g]) begin
                            state_r <= NS_SNK_ACKED;
                            ack_r   <= NS_ON;
                        end else if (err_s[g]) begin
                            state_r <= NS_SNK_ERR;
                            ack_r   <= NS_OFF;
                        end else begin
                            state_r <= NS_SNK_IDLE;
                            ack_r   <= NS_OFF;
                        end
                    end
                    NS_SNK_ACKED: begin
                        if (!ckd_s[g]) begin
                            state_r <= NS_SNK_IDLE;
                            ack_r   <= NS_OFF;
                        end else begin
                            state_r <= NS_SNK_ACKED;
                            ack_r   <= NS_ON;
                        end
                    end
                    NS_SNK_ERR: begin
                        state_r <= NS_SNK_ERR;
                        ack_r   <= NS_OFF;
                    end
                    default: begin
                        state_r <= NS_SNK_IDLE;
                        ack_r   <= NS_OFF;
                    end
                endcase
            end
        end

        // Per-channel accept counter, saturating at all-ones.
        always_ff @(posedge gch_clk or posedge gch_reset) begin
            if (gch_reset) begin
                cnt_r <= CNT_SZ'(0);
            end else if (accept_s[g] && (cnt_r != {CNT_SZ{1'b1}})) begin
                cnt_r <= cnt_r + CNT_SZ'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end

        assign rcv_ack_out[g]                 = ack_r;
        assign msg_cnt[g*CNT_SZ +: CNT_SZ]    = cnt_r;
    end

    // Fold every word accepted this cycle into the running XOR.
    always_comb begin
        xor_next_s = dat_xor_r;
        for (int i = 0; i < NUM_CHNLS; i++) begin
            if (accept_s[i]) begin
                xor_next_s = xor_next_s ^ rcv_dat[i*DSZ +: DSZ];
            end else begin
                xor_next_s = xor_next_s;
            end
        end
    end

    // Saturating total plus the done condition it implies this cycle.
    always_comb begin
        pop_s = popcount16(16'(accept_s));
        sum_s = SUM_SZ'(total_r) + SUM_SZ'(pop_s);
        if (sum_s > SUM_SZ'(TOT_MAX)) begin
            total_next_s = TOT_MAX;
        end else begin
            total_next_s = TOT_SZ'(sum_s);
        end
        done_next_s = done_r ||
                      ((EXPECTED != 0) && (64'(total_next_s) >= 64'(EXPECTED)));
    end

    // Error arbitration: walk from the top so the lowest index is kept.
    always_comb begin
        err_any_s     = 1'b0;
        err_sel_chn_s = CHW'(0);
        err_sel_src_s = ASZ'(0);
        err_sel_dst_s = ASZ'(0);
        err_sel_dat_s = DSZ'(0);
        for (int i = NUM_CHNLS - 1; i >= 0; i--) begin
            if (err_s[i]) begin
                err_any_s     = 1'b1;
                err_sel_chn_s = CHW'(i);
                err_sel_src_s = rcv_src[i*ASZ +: ASZ];
                err_sel_dst_s = rcv_dst[i*ASZ +: ASZ];
                err_sel_dat_s = rcv_dat[i*DSZ +: DSZ];
            end else begin
                err_any_s     = err_any_s;
            end
        end
    end

    // Global accounting registers and the first-error record.
    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            init_r    <= NS_OFF;
            total_r   <= TOT_SZ'(0);
            dat_xor_r <= DSZ'(0);
            done_r    <= NS_OFF;
            err_r     <= NS_OFF;
            err_chn_r <= CHW'(0);
            err_src_r <= ASZ'(0);
            err_dst_r <= ASZ'(0);
            err_dat_r <= DSZ'(0);
        end else begin
            init_r    <= NS_ON;
            total_r   <= total_next_s;
            dat_xor_r <= xor_next_s;
            done_r    <= done_next_s;
            if (err_any_s && !err_r) begin
                err_r     <= NS_ON;
                err_chn_r <= err_sel_chn_s;
                err_src_r <= err_sel_src_s;
                err_dst_r <= err_sel_dst_s;
                err_dat_r <= err_sel_dat_s;
            end else begin
                err_r     <= err_r;
                err_chn_r <= err_chn_r;
                err_src_r <= err_src_r;
                err_dst_r <= err_dst_r;
                err_dat_r <= err_dat_r;
            end
        end
    end

    assign gch_ready  = init_r && (&rdy_s);
    assign dat_xor    = dat_xor_r;
    assign done       = done_r;
    assign err0_error = err_r;
    assign err0_chn   = err_chn_r;
    assign err0_src   = err_src_r;
    assign err0_dst   = err_dst_r;
    assign err0_dat   = err_dat_r;

endmodule
